// File: rtl/mem_req_pkg.sv
// Shared types for the memory request front-end: default widths, FSM state
// encoding, the buffered request record and the parity helper.
package mem_req_pkg;

    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD_WAIT,
        RESP
    } mem_ctrl_state_e;

    // One queued request. Field widths follow the package defaults.
    typedef struct packed {
        logic                  wr;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } mem_req_t;

    // Even parity: the MSB must equal the XOR of the data bits.
    function automatic logic parity_ok(input logic [DEF_DATA_W:0] word);
        return word[DEF_DATA_W] == ^word[DEF_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// Synchronous request FIFO of mem_req_t records. The pointers carry one extra
// wrap bit, so full and empty come straight from registered state. The head
// entry is presented combinationally (show-ahead).
module mem_req_fifo
    import mem_req_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  mem_req_t push_data,
    input  logic     pop,
    output mem_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0] wr_ptr;
    logic [PTR_W:0] rd_ptr;
    mem_req_t       entries [DEPTH];
    logic           do_push;
    logic           do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);

    // A push while full is legal when the head leaves in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    assign head = entries[rd_ptr[PTR_W-1:0]];

    // Pointer update; occupancy is implied by the pointer difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Entry storage; contents are only visible once a pointer covers them.
    // NOTE: no reset on the storage array, it keeps it a plain RAM/regfile.
    always_ff @(posedge clk) begin
        if (do_push) entries[wr_ptr[PTR_W-1:0]] <= push_data;
    end

endmodule

// File: rtl/mem_req_ctrl.sv
// Request front-end for the parity memory. Requests arrive on a valid/ready
// port, queue in mem_req_fifo and are replayed one at a time onto the memory
// write/read strobes. Read words are parity-checked on the way back.
// Build option: define MEM_REQ_CTRL_ERR_CNT_EN to implement the saturating
// parity-error counter; otherwise err_count is tied to zero.
module mem_req_ctrl
    import mem_req_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int DEPTH    = 4,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W:0]   mem_data_out,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_perr,
    output logic              busy,
    output logic [15:0]       err_count
);

    localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

    mem_ctrl_state_e state;
    mem_req_t        fifo_in;
    mem_req_t        head;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_pop;
    logic [CNT_W-1:0] rd_cnt;
    logic [DATA_W:0]  rd_word;

    assign fifo_in   = '{wr: req_wr, addr: req_addr, wdata: req_wdata};
    assign req_ready = !fifo_full;
    assign fifo_pop  = (state == IDLE) && !fifo_empty;

    mem_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (req_valid && req_ready),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Sequencer: issue one memory operation per request with an IDLE gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_write   <= 1'b0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            mem_data_in <= '0;
            rd_cnt      <= '0;
            rd_word     <= '0;
            rsp_valid   <= 1'b0;
        end else begin
            mem_write <= 1'b0;
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        mem_address <= head.addr;
                        mem_data_in <= head.wdata;
                        if (head.wr) begin
                            mem_write <= 1'b1;
                            state     <= WR;
                        end else begin
                            mem_read <= 1'b1;
                            rd_cnt   <= CNT_W'(READ_LAT - 1);
                            state    <= RD_WAIT;
                        end
                    end
                end
                WR: begin
                    state <= IDLE;
                end
                RD_WAIT: begin
                    if (rd_cnt == '0) begin
                        rd_word   <= mem_data_out;
                        mem_read  <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else begin
                        rd_cnt <= rd_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rsp_data = rd_word[DATA_W-1:0];
    assign rsp_perr = !parity_ok(rd_word);
    assign busy     = (state != IDLE) || !fifo_empty;

`ifdef MEM_REQ_CTRL_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating count of responses that failed the parity check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (rsp_valid && rsp_perr && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

    a_strobe_mutex: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_write && mem_read));

endmodule
